store_monitor: RTL
==================

Name: store_monitor

Overview:
- Synthesizable completion monitor directly downstream of Single_Cycle_Top's data-memory bus (MemWrite, DataAddr, WriteData).
- Counts cycles and stores, and logs every store into a small FIFO a bench or debug port can drain.
- Declares PASS/FAIL when the program writes the tohost address, or TIMEOUT if no such write arrives in time.
- Replaces fixed-cycle $stop benches with a self-checking end condition.

Parameters:
- TOHOST_ADDR, 32'h0000_0064, store address that ends the test.
- PASS_VALUE, 32'd25, WriteData value at TOHOST_ADDR that means pass; any other value means fail.
- TIMEOUT_CYCLES, 1000, RUN cycles allowed before TIMEOUT.
- LOG_DEPTH, 8, store-log FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- run_en  in  1  level; starts monitoring when the block is in IDLE.
- MemWrite  in  1  core store strobe, one store per cycle.
- DataAddr  in  32  store address.
- WriteData  in  32  store data.
- status  out  2  00 IDLE/RUN, 01 PASS, 10 FAIL, 11 TIMEOUT.
- done  out  1  high in any terminal state.
- cycle_count  out  32  RUN cycles elapsed.
- store_count  out  16  stores accepted in RUN; saturates at 16'hFFFF.
- log_rd_en  in  1  pop request for the store log.
- log_valid  out  1  log is non-empty; head entry on log_addr/log_data.
- log_addr  out  32  head entry address.
- log_data  out  32  head entry data.
- log_overflow  out  1  sticky; a store was dropped because the log was full.

Behaviour:
- Reset: sampled only on the rising clk edge while reset==0.
  - All outputs go to 0, FSM to IDLE, FIFO empties.
  - Reset mid-RUN or in a terminal state aborts and clears everything the same way.
- FSM states and transitions:
  - IDLE -> RUN on the first edge with run_en==1. Stores during IDLE are ignored: not counted, not logged.
  - RUN, store at TOHOST_ADDR: go to PASS if WriteData==PASS_VALUE, else to FAIL.
  - RUN, timeout: go to TIMEOUT when cycle_count reaches TIMEOUT_CYCLES-1 and that same edge carries no tohost store. A tohost store on that edge wins, giving PASS/FAIL.
  - PASS/FAIL/TIMEOUT are sticky until reset. run_en is ignored there, and stores are neither counted nor logged.
- Latency: status/done update on the edge that samples the tohost store, visible the next cycle. No combinational path from the inputs to status.
- cycle_count:
  - Increments every RUN cycle, starting at 0 on the first RUN cycle.
  - Freezes on entering a terminal state.
  - Wraps modulo 2^32; this is unreachable while TIMEOUT_CYCLES < 2^32.
- store_count increments per MemWrite in RUN, including the tohost store.
- Store log:
  - Every store accepted in RUN, including the tohost store, pushes {DataAddr, WriteData}.
  - First-word-fall-through: log_addr/log_data/log_valid are registered outputs showing the head entry.
  - log_rd_en with log_valid==0 is ignored.
  - log_addr/log_data hold their last value when empty.
- Boundary conditions:
  - Full with no pop: the push is dropped, log_overflow is set, and store_count still increments.
  - Full with a simultaneous pop: pop and push both happen, and no overflow is flagged.
  - Empty with a simultaneous push and pop: the pop is ignored and the push succeeds.
  - Read and write pointers wrap modulo LOG_DEPTH. An extra pointer bit distinguishes full from empty.
  - The log stays readable in terminal states; pops work until reset.

Decomposition:
- Shared package (monitor_pkg) holds:
  - the status encoding (ST_RUN=2'b00, ST_PASS=2'b01, ST_FAIL=2'b10, ST_TIMEOUT=2'b11);
  - FSM state localparams (S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT);
  - default TOHOST_ADDR and PASS_VALUE.
- One sub-module, store_log_fifo: synchronous FWFT FIFO with parameters WIDTH=64 and DEPTH=LOG_DEPTH, and ports push, pop, din, dout, empty, full.
- store_monitor owns the FSM, the counters and the overflow flag.

Test Plan:
1. Store at TOHOST_ADDR with data 25 in the 5th RUN cycle.
   - Next cycle: status=01, done=1, cycle_count=4.
   - store_count=1; log holds {0x64, 25}.
2. Stores to 0x10 with data 7, then to 0x64 with data 3.
   - status=10 (FAIL), store_count=2.
   - Two pops return {0x10, 7} then {0x64, 3}; log_valid then drops to 0.
3. No tohost store with TIMEOUT_CYCLES=20.
   - status=11 after 20 RUN cycles, cycle_count frozen at 19.
   - A tohost store with data 25 on the same edge instead yields PASS.
4. 10 consecutive stores with LOG_DEPTH=8 and no pops.
   - log_overflow=1, store_count=10, log holds the first 8 entries in order.
   - Repeat popping every cycle while full: no overflow.
5. Reach RUN with store_count=3, then drive reset=0 for one edge.
   - All outputs 0, FIFO empty, FSM IDLE.
   - Stores while run_en=0 are not counted.
6. After PASS, further stores and run_en pulses leave status, cycle_count and store_count unchanged.

Source files
------------

// File: rtl/monitor_pkg.sv
// ============================================================================
// monitor_pkg : status codes, FSM states and defaults for store_monitor
// Rev 1.0
// ============================================================================
`default_nettype none

package monitor_pkg;

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_PASS    = 2'b01;
  localparam logic [1:0] ST_FAIL    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_PASS    = 3'd2;
  localparam logic [2:0] S_FAIL    = 3'd3;
  localparam logic [2:0] S_TIMEOUT = 3'd4;

  localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_0064;
  localparam logic [31:0] DEF_PASS_VALUE  = 32'd25;

endpackage

`default_nettype wire

// File: rtl/store_log_fifo.sv
// ============================================================================
// store_log_fifo : synchronous first-word-fall-through FIFO, registered head
// Rev 1.0
// ============================================================================
`default_nettype none

module store_log_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             pop_ok, push_ok;

  assign empty   = (rd_ptr_q == wr_ptr_q);
  assign full    = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = dout_q;

  // Head register tracks the new front; the entry written this edge is not yet in mem_q.
  always_comb begin
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    dout_d   = dout_q;
    if (rd_ptr_d != wr_ptr_d) begin
      if (push_ok && (rd_ptr_d == wr_ptr_q)) dout_d = din;
      else                                   dout_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      dout_q   <= dout_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/store_monitor.sv
// ============================================================================
// store_monitor : data-memory store watcher with PASS/FAIL/TIMEOUT verdict
// Rev 1.0
// ============================================================================
`default_nettype none

module store_monitor
  import monitor_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = DEF_TOHOST_ADDR,
  parameter logic [31:0] PASS_VALUE     = DEF_PASS_VALUE,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int          LOG_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_en,
  input  logic        MemWrite,
  input  logic [31:0] DataAddr,
  input  logic [31:0] WriteData,
  output logic [1:0]  status,
  output logic        done,
  output logic [31:0] cycle_count,
  output logic [15:0] store_count,
  input  logic        log_rd_en,
  output logic        log_valid,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow
);

  localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] cycle_q, cycle_d;
  logic [15:0] store_q, store_d;
  logic        ovf_q, ovf_d;
  logic        in_run, accept, hit_tohost;
  logic        log_empty, log_full, log_pop;
  logic [63:0] log_head;

  assign in_run     = (state_q == S_RUN);
  assign accept     = in_run && MemWrite;
  assign hit_tohost = accept && (DataAddr == TOHOST_ADDR);
  assign log_pop    = log_rd_en && !log_empty;

  // A tohost store on the final allowed cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (run_en) state_d = S_RUN;
      S_RUN: begin
        if (hit_tohost)                state_d = (WriteData == PASS_VALUE) ? S_PASS : S_FAIL;
        else if (cycle_q == LAST_CYCLE) state_d = S_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

  assign cycle_d = (in_run && (state_d == S_RUN)) ? cycle_q + 32'd1 : cycle_q;
  assign store_d = (accept && (store_q != 16'hFFFF)) ? store_q + 16'd1 : store_q;
  assign ovf_d   = ovf_q | (accept && log_full && !log_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cycle_q <= '0;
      store_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      store_q <= store_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    status = ST_RUN;
    case (state_q)
      S_PASS:    status = ST_PASS;
      S_FAIL:    status = ST_FAIL;
      S_TIMEOUT: status = ST_TIMEOUT;
      default:   status = ST_RUN;
    endcase
  end

  assign done         = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TIMEOUT);
  assign cycle_count  = cycle_q;
  assign store_count  = store_q;
  assign log_overflow = ovf_q;
  assign log_valid    = !log_empty;
  assign log_addr     = log_head[63:32];
  assign log_data     = log_head[31:0];

  store_log_fifo #(
    .WIDTH (64),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (log_pop),
    .din   ({DataAddr, WriteData}),
    .dout  (log_head),
    .empty (log_empty),
    .full  (log_full)
  );

endmodule

`default_nettype wire
